hamming_enc_engine: RTL and testbench

HAMMING_ENC_ENGINE -- requirements
Module: hamming_enc_engine

---
 rtl/hamming_pkg.sv | 47 ++++
 rtl/hamming_enc.sv | 20 ++
 rtl/hamming_enc_engine.sv | 178 +++++++++++++++++
 tb/tb_hamming_enc_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the Hamming(16,11) SECDED encoder engine and the
// matching decoder: engine FSM state encoding, parameter defaults, parity
// bit positions inside the 16-bit codeword and the encode helper function.
// No ports (package).
// ---------------------------------------------------------------------------
package hamming_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // Default engine parameters
    localparam int NUM_MSG_DEFAULT  = 15;
    localparam int SRC_BASE_DEFAULT = 0;
    localparam int DST_BASE_DEFAULT = 30;

    // Parity bit positions inside c[15:0]; data bits fill the remaining slots
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Encode d[11:1] into the extended Hamming codeword (p0 = overall parity)
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc.sv
// ---------------------------------------------------------------------------
// hamming_enc
// Purely combinational Hamming(16,11) SECDED encoder.
// Ports:
//   d [11:1]  input   11-bit message, d[1] is the least significant bit
//   c [15:0]  output  codeword {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}
// ---------------------------------------------------------------------------
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [11:1] d,
    output logic [15:0] c
);

    // Codeword generation
    always_comb begin
        c = hamming_encode(d);
    end

endmodule

// File: rtl/hamming_enc_engine.sv
// ---------------------------------------------------------------------------
// hamming_enc_engine
// Reads NUM_MSG 11-bit messages (two bytes each) from a byte-wide data
// memory, encodes each with hamming_enc and writes the 16-bit codewords back
// as two bytes. Four cycles per message, done pulses high after the last
// write and stays high in IDLE until the next accepted start.
// Ports:
//   clk        input   clock, all state updates on posedge
//   reset      input   synchronous active-high reset (priority over start)
//   start      input   run request, sampled only in IDLE
//   done       output  run complete (registered)
//   mem_addr   output  8-bit memory byte address (registered)
//   mem_rdata  input   memory read data, combinational from mem_addr
//   mem_wdata  output  memory write data (registered)
//   mem_we     output  memory write enable (registered)
// ---------------------------------------------------------------------------
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = NUM_MSG_DEFAULT,
    parameter int SRC_BASE = SRC_BASE_DEFAULT,
    parameter int DST_BASE = DST_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we
);

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 32'sd1);

    // Both regions must fit in the 8-bit address space; index is 7 bits wide
    generate
        if (NUM_MSG < 32'sd1 || NUM_MSG > 32'sd128) begin : g_bad_num_msg
            $error("hamming_enc_engine: NUM_MSG out of range 1..128");
        end
        if ((SRC_BASE + 32'sd2 * NUM_MSG > 32'sd256) ||
            (DST_BASE + 32'sd2 * NUM_MSG > 32'sd256)) begin : g_bad_region
            $error("hamming_enc_engine: message or codeword region exceeds 256 bytes");
        end
    endgenerate

    state_e      state_r;
    state_e      state_nxt_s;
    logic [6:0]  idx_r;
    logic [6:0]  idx_nxt_s;
    logic [6:0]  idx_inc_s;
    logic [7:0]  lo_r;
    logic [7:0]  lo_nxt_s;
    logic [2:0]  hi_r;
    logic [2:0]  hi_nxt_s;
    logic [2:0]  hi_sel_s;
    logic [7:0]  addr_r;
    logic [7:0]  addr_nxt_s;
    logic [7:0]  wdata_r;
    logic [7:0]  wdata_nxt_s;
    logic        we_r;
    logic        we_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic [7:0]  src_lo_s;
    logic [7:0]  dst_lo_s;
    logic [15:0] code_s;

    assign idx_inc_s = idx_r + 7'd1;
    assign src_lo_s  = SRC_B + {idx_r, 1'b0};
    assign dst_lo_s  = DST_B + {idx_r, 1'b0};

    // Encoder data: while in RD_HI the high byte is still on mem_rdata, so
    // the low codeword byte can be loaded into the write-data register as
    // the FSM enters WR_LO.
    always_comb begin
        if (state_r == ST_RD_HI) begin
            hi_sel_s = mem_rdata[2:0];
        end else begin
            hi_sel_s = hi_r;
        end
    end

    hamming_enc u_enc (
        .d ({hi_sel_s, lo_r}),
        .c (code_s)
    );

    // Next-state logic; memory outputs are computed for the state being
    // entered so that the registered outputs line up with the state.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        lo_nxt_s    = lo_r;
        hi_nxt_s    = hi_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        we_nxt_s    = 1'b0;
        done_nxt_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RD_LO;
                    idx_nxt_s   = 7'd0;
                    done_nxt_s  = 1'b0;
                    addr_nxt_s  = SRC_B;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_LO: begin
                lo_nxt_s    = mem_rdata;
                state_nxt_s = ST_RD_HI;
                addr_nxt_s  = src_lo_s + 8'd1;
            end
            ST_RD_HI: begin
                hi_nxt_s    = mem_rdata[2:0];
                state_nxt_s = ST_WR_LO;
                addr_nxt_s  = dst_lo_s;
                wdata_nxt_s = code_s[7:0];
                we_nxt_s    = 1'b1;
            end
            ST_WR_LO: begin
                state_nxt_s = ST_WR_HI;
                addr_nxt_s  = dst_lo_s + 8'd1;
                wdata_nxt_s = code_s[15:8];
                we_nxt_s    = 1'b1;
            end
            ST_WR_HI: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    idx_nxt_s   = idx_inc_s;
                    state_nxt_s = ST_RD_LO;
                    addr_nxt_s  = SRC_B + {idx_inc_s, 1'b0};
                end
            end
            ST_FIN: begin
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 7'd0;
            lo_r    <= 8'd0;
            hi_r    <= 3'd0;
            addr_r  <= 8'd0;
            wdata_r <= 8'd0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            lo_r    <= lo_nxt_s;
            hi_r    <= hi_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            we_r    <= we_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_we    = we_r;
    assign done      = done_r;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// ---------------------------------------------------------------------------
// tb_hamming_enc_engine
// Scoreboard bench: expected memory writes are queued when a run is set up,
// a negedge monitor pops and compares on every DUT write. Directed message
// table with hand-computed codewords for the first entries and an
// independent position-based Hamming model for the rest.
// ---------------------------------------------------------------------------
module tb_hamming_enc_engine;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       load_img = 1'b0;

    logic [7:0] mem      [0:255];
    logic [7:0] init_img [0:255];
    logic [7:0] exp_img  [0:255];
    wr_t        exp_q[$];

    int errors = 0;
    int checks = 0;

    // Message table: {hi, lo}; high bytes carry garbage in bits [7:3]
    logic [7:0] msg_lo [0:N-1] = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h5C,
                                   8'h96, 8'h00, 8'h81, 8'hAA, 8'h3C, 8'hF0, 8'h11, 8'h80};
    logic [7:0] msg_hi [0:N-1] = '{8'h07, 8'hA8, 8'hF8, 8'hF8, 8'h04, 8'h00, 8'hA3,
                                   8'h1E, 8'hFF, 8'h02, 8'h55, 8'h06, 8'h01, 8'h7D, 8'h00};
    // Hand-computed codewords for messages 0..5
    // 0x7FF->FFFF, 0x000->0000, 0x001->000F, 0x000(0xF8 garbage)->0000,
    // 0x400->8117 (pos 15 sets p1,p2,p4,p8,p0), 0x002->0033 (pos 5 sets p1,p4,p0)
    logic [15:0] hand_code [0:5] = '{16'hFFFF, 16'h0000, 16'h000F, 16'h0000, 16'h8117, 16'h0033};

    // Clock generation
    always #5 clk = ~clk;

    hamming_enc_engine #(
        .NUM_MSG  (N),
        .SRC_BASE (SRC),
        .DST_BASE (DST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    assign mem_rdata = mem[mem_addr];

    // Data memory: image load from the bench or a DUT write
    always @(posedge clk) begin
        if (load_img) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_img[a];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Extended Hamming by bit positions: data in non-power-of-2 slots 3..15
    function automatic logic [15:0] model_encode(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        int          k;
        c = 16'h0000;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int pb = 1; pb < 16; pb = pb * 2) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (((pos & pb) != 0) && (pos != pb)) p = p ^ c[pos];
            end
            c[pb] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic syndrome_ok(input logic [15:0] c);
        logic [3:0] syn;
        syn = 4'd0;
        for (int pos = 1; pos < 16; pos++) begin
            if (c[pos]) syn = syn ^ 4'(pos);
        end
        return (syn == 4'd0) && ((^c) == 1'b0);
    endfunction

    function automatic logic [15:0] exp_code(input int i);
        if (i < 6) return hand_code[i];
        return model_encode({msg_hi[i][2:0], msg_lo[i]});
    endfunction

    // Scoreboard monitor: every DUT write must match the next queued entry
    always @(negedge clk) begin : mon
        wr_t w;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write at %0t",
                         mem_addr, mem_wdata, $time);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, w.addr});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, w.data});
            end
        end
    end

    // Build memory image, expected image and expected write queue
    task automatic prepare(input int n_wr);
        logic [15:0] c;
        for (int a = 0; a < 256; a++) init_img[a] = 8'(a) ^ 8'hA5;
        for (int i = 0; i < N; i++) begin
            init_img[SRC + 2 * i]     = msg_lo[i];
            init_img[SRC + 2 * i + 1] = msg_hi[i];
        end
        for (int a = 0; a < 256; a++) exp_img[a] = init_img[a];
        exp_q.delete();
        for (int i = 0; i < n_wr; i++) begin
            c = exp_code(i);
            exp_img[DST + 2 * i]     = c[7:0];
            exp_img[DST + 2 * i + 1] = c[15:8];
            exp_q.push_back('{addr: 8'(DST + 2 * i),     data: c[7:0]});
            exp_q.push_back('{addr: 8'(DST + 2 * i + 1), data: c[15:8]});
        end
        @(posedge clk); #1 load_img = 1'b1;
        @(posedge clk); #1 load_img = 1'b0;
    endtask

    // One run; edge numbers count posedges after the start-sampling edge
    task automatic do_run(input int restart_edge, input int reset_edge);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("done_cleared", {31'd0, done}, 32'd0);
        for (int e = 1; e <= 61; e++) begin
            if (e == restart_edge) start = 1'b1;
            if (e == reset_edge) reset = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (e == reset_edge) begin
                check("reset_done", {31'd0, done}, 32'd0);
                check("reset_we", {31'd0, mem_we}, 32'd0);
                reset = 1'b0;
                break;
            end
            if (e == 60) check("done_early", {31'd0, done}, 32'd0);
            if (e == 61) check("done_at_61", {31'd0, done}, 32'd1);
        end
    endtask

    task automatic finish_run(input logic exp_done, input int n_wr);
        int          mism;
        logic [15:0] c;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", {31'd0, done}, {31'd0, exp_done});
        check("queue_drain", exp_q.size(), 32'd0);
        mism = 0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== exp_img[a]) mism++;
        end
        check("mem_image_mismatches", mism, 32'd0);
        for (int i = 0; i < n_wr; i++) begin
            c = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            check("decode_syndrome", {31'd0, syndrome_ok(c)}, 32'd1);
        end
    endtask

    // Main stimulus sequence
    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_done", {31'd0, done}, 32'd0);
        check("por_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;

        // Normal run
        prepare(N);
        do_run(0, 0);
        finish_run(1'b1, N);

        // start re-pulsed mid-run is ignored
        prepare(N);
        do_run(20, 0);
        finish_run(1'b1, N);

        // Reset at edge 30 aborts before message 7 is written
        prepare(7);
        do_run(0, 30);
        finish_run(1'b0, 7);

        // Run after the abort completes normally
        prepare(N);
        do_run(0, 0);
        finish_run(1'b1, N);

        // Reset and start in the same cycle: reset wins, no run starts
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_done", {31'd0, done}, 32'd0);
        check("rst_start_we", {31'd0, mem_we}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("rst_start_idle_done", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
